fmap_buf: RTL and testbench
===========================

# fmap_buf

Ping-pong feature-map buffer sitting between two convolution layers. The producing layer's output write port (`we`/`wa`/`wd` plus a completion pulse) fills one bank while the consuming layer's input read port (`ra`/`rd`, one-cycle registered latency) drains the other. Bank ownership moves through a per-bank state machine, so a layer's output becomes the next layer's input without a copy or a global stall.

## Interface

Parameters:
- `DATA_SIZE`, 16, word width.
- `MEM_SIZE`, 16, address port width.
- `DEPTH_BITS`, 12, per-bank storage depth is 2**DEPTH_BITS words (must be ≤ MEM_SIZE).

Ports:
- `clk`  input  1  clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `wr_start`  input  1  producer pulse: claim a bank for writing.
- `wr_ready`  output  1  a bank is granted to the producer (bank[wptr]==WRITE).
- `we`  input  1  write strobe.
- `wa`  input  MEM_SIZE  write address.
- `wd`  input  DATA_SIZE  write data.
- `wr_done`  input  1  producer pulse: bank complete.
- `rd_ready`  output  1  a FULL bank is available (bank[rptr]==FULL).
- `rd_start`  input  1  consumer pulse: claim the FULL bank for reading.
- `rd_busy`  output  1  bank[rptr]==READ.
- `ra`  input  MEM_SIZE  read address.
- `rd`  output  DATA_SIZE  registered read data.
- `rd_len`  output  MEM_SIZE  highest written address + 1 of bank[rptr]; 0 if nothing written.
- `rd_release`  input  1  consumer pulse: bank consumed.
- `err`  output  1  sticky protocol/range error.

## Operation

- Two banks (0, 1), each with a 2-bit state: EMPTY → WRITE → FULL → READ → EMPTY. There is also a write pointer `wptr` and a read pointer `rptr`, both 1 bit. Banks are used strictly in alternation, so output order is FIFO.
- EMPTY→WRITE: `wr_start` while bank[wptr]==EMPTY. The bank's high-water register clears to 0.
- WRITE→FULL: `wr_done` while bank[wptr]==WRITE. `wptr` toggles.
- FULL→READ: `rd_start` while bank[rptr]==FULL.
- READ→EMPTY: `rd_release` while bank[rptr]==READ. `rptr` toggles.
- Accepted write: `we && wr_ready && wa < 2**DEPTH_BITS`. It stores `wd` into bank[wptr] at `wa` and sets the high-water mark to max(hw, wa+1).
- Rejected write: `we` with `!wr_ready`, or `wa` out of range. Memory is not modified and `err` is set.
- Read: when `rd_busy` and `ra` is in range, `rd` equals bank[rptr][ra], one cycle later. Otherwise `rd` loads 0. An out-of-range `ra` while `rd_busy` sets `err`.
- Control pulses given in the wrong state set `err` and are otherwise ignored:
  - `wr_done` with bank[wptr]!=WRITE;
  - `rd_start` with bank[rptr]!=FULL;
  - `rd_release` with bank[rptr]!=READ.
- `wr_start` with bank[wptr]==WRITE is a harmless no-op.
- `wr_start` with bank[wptr] FULL or READ (back-pressure) is ignored. It does not set `err`, and the producer must retry.
- Simultaneous events:
  - `wr_done` and `rd_release` on different banks both take effect in the same cycle.
  - `wr_start` and `wr_done` together: `wr_done` is applied and `wr_start` is ignored.
  - `we` and `wr_done` together: the write is accepted, then the bank becomes FULL.
  - Reads and writes never share a bank, because the states are exclusive.
- `err` clears only on reset.

## Timing

- Reset values:
  - all banks EMPTY; `wptr` = `rptr` = 0;
  - `wr_ready`, `rd_ready`, `rd_busy` and `err` are 0;
  - `rd` = 0, `rd_len` = 0.
  - Memory contents are not reset.
- Asserting reset mid-operation abandons both banks immediately, asynchronously.
- State outputs (`wr_ready`, `rd_ready`, `rd_busy`, `rd_len`) are decoded from registered state. They change in the cycle after the causing pulse.
- A write issued in the same cycle `wr_ready` first rises is accepted.
- Read latency is exactly 1 cycle: `ra` at edge t gives `rd` after edge t+1. This matches the consumer's two-stage address/data pipeline.
- `rd_len` reflects writes through the final `we` cycle, including one coincident with `wr_done`.
- Throughput: one write and one read per cycle, sustained.

## Test plan

- **Reset:** assert `rst`=0 mid-WRITE with data pending → all outputs go to 0 at once; after release, `wr_start` grants bank 0 (`wr_ready`=1 next cycle).
- **Single pass:**
  - `wr_start`, then write wa=0..7 with wd=0x100+wa, then `wr_done` → `rd_ready`=1 and `rd_len`=8.
  - `rd_start`, then ra=3 → `rd`=0x103 one cycle later.
  - `rd_release` → `rd_ready`=0 and `rd_busy`=0.
- **Ping-pong overlap:**
  - Fill bank 0, `rd_start` it, and concurrently fill bank 1 with 0x200+wa.
  - Issue bank-0 `rd_release` and bank-1 `wr_done` in the same cycle → next cycle `rd_ready`=1 and ra=5 reads 0x205.
- **Back-pressure:** both banks FULL, `wr_start` → `wr_ready` stays 0 and `err`=0. After one `rd_start`/`rd_release`, a retried `wr_start` is granted.
- **Errors:**
  - `we` with `wr_ready`=0 → `err`=1 and memory unchanged.
  - After reset, wa=4096 (DEPTH_BITS=12) → `err`=1 and `rd_len` unaffected.
  - `rd_start` with no FULL bank → `err`=1.
- **Sparse/last-write:** write only wa=10, together with `wr_done` → write accepted, `rd_len`=11, ra=10 returns the data, ra=0 returns stale or undefined memory (not checked).

Source files
------------

// File: rtl/fmap_buf.sv
// fmap_buf: ping-pong feature-map buffer between two convolution layers.
// Two banks alternate between a producer (write port) and a consumer
// (registered read port). Each bank steps EMPTY -> WRITE -> FULL -> READ
// -> EMPTY, so one layer's output becomes the next layer's input in place.
module fmap_buf #(
    parameter int DATA_SIZE  = 16,
    parameter int MEM_SIZE   = 16,
    parameter int DEPTH_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_start,
    output logic                 wr_ready,
    input  logic                 we,
    input  logic [MEM_SIZE-1:0]  wa,
    input  logic [DATA_SIZE-1:0] wd,
    input  logic                 wr_done,
    output logic                 rd_ready,
    input  logic                 rd_start,
    output logic                 rd_busy,
    input  logic [MEM_SIZE-1:0]  ra,
    output logic [DATA_SIZE-1:0] rd,
    output logic [MEM_SIZE-1:0]  rd_len,
    input  logic                 rd_release,
    output logic                 err
);

    localparam int NWORDS = 2 ** DEPTH_BITS;
    // High-water mark must hold NWORDS itself, hence one extra bit.
    localparam int HW_W = DEPTH_BITS + 1;
    localparam logic [MEM_SIZE:0] DEPTH_LIM = (MEM_SIZE + 1)'(NWORDS);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2,
        READ  = 2'd3
    } bank_state_e;

    // Registered state
    bank_state_e          state_q [2];
    bank_state_e          state_d [2];
    logic                 wptr_q, wptr_d;
    logic                 rptr_q, rptr_d;
    logic [HW_W-1:0]      hw_q [2];
    logic [HW_W-1:0]      hw_d [2];
    logic [DATA_SIZE-1:0] rd_q, rd_d;
    logic                 err_q, err_d;

    // Both banks share one array; the bank number is the top index bit.
    logic [DATA_SIZE-1:0] mem [2*NWORDS];

    // Decoded control
    bank_state_e          wstate;
    bank_state_e          rstate;
    logic                 wa_ok;
    logic                 ra_ok;
    logic                 wr_accept;
    logic                 rd_en;
    logic [DEPTH_BITS:0]  wr_idx;
    logic [DEPTH_BITS:0]  rd_idx;
    logic [HW_W-1:0]      hw_cand;

    // Decode the states of the banks the two pointers select, plus range checks.
    always_comb begin
        wstate    = state_q[wptr_q];
        rstate    = state_q[rptr_q];
        wa_ok     = ({1'b0, wa} < DEPTH_LIM);
        ra_ok     = ({1'b0, ra} < DEPTH_LIM);
        wr_accept = we && (wstate == WRITE) && wa_ok;
        rd_en     = (rstate == READ) && ra_ok;
        wr_idx    = {wptr_q, wa[DEPTH_BITS-1:0]};
        rd_idx    = {rptr_q, ra[DEPTH_BITS-1:0]};
        hw_cand   = {1'b0, wa[DEPTH_BITS-1:0]} + HW_W'(1);
    end

    // Next-state logic for bank states, pointers, high-water marks and err.
    always_comb begin
        state_d = state_q;
        hw_d    = hw_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        err_d   = err_q;

        // Producer side: the write lands before a coincident wr_done closes the bank.
        if (wr_accept && (hw_cand > hw_q[wptr_q])) begin
            hw_d[wptr_q] = hw_cand;
        end
        if (we && !wr_accept) begin
            err_d = 1'b1;
        end

        if (wr_done) begin
            if (wstate == WRITE) begin
                state_d[wptr_q] = FULL;
                wptr_d          = ~wptr_q;
            end else begin
                err_d = 1'b1;
            end
        end else if (wr_start && (wstate == EMPTY)) begin
            // WRITE is a no-op; FULL/READ is back-pressure, silently retried.
            state_d[wptr_q] = WRITE;
            hw_d[wptr_q]    = '0;
        end

        // Consumer side: FULL and READ are exclusive, so at most one pulse acts.
        if (rd_start) begin
            if (rstate == FULL) begin
                state_d[rptr_q] = READ;
            end else begin
                err_d = 1'b1;
            end
        end
        if (rd_release) begin
            if (rstate == READ) begin
                state_d[rptr_q] = EMPTY;
                rptr_d          = ~rptr_q;
            end else begin
                err_d = 1'b1;
            end
        end

        if ((rstate == READ) && !ra_ok) begin
            err_d = 1'b1;
        end
    end

    // Read data path: one registered stage, zero when no valid read.
    always_comb begin
        rd_d = '0;
        if (rd_en) begin
            rd_d = mem[rd_idx];
        end
    end

    // Control and read-data registers, abandoned asynchronously on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned b = 0; b < 2; b++) begin
                state_q[b] <= EMPTY;
                hw_q[b]    <= '0;
            end
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            rd_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int unsigned b = 0; b < 2; b++) begin
                state_q[b] <= state_d[b];
                hw_q[b]    <= hw_d[b];
            end
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            rd_q   <= rd_d;
            err_q  <= err_d;
        end
    end

    // Storage array, not reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_idx] <= wd;
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
        wr_ready = (wstate == WRITE);
        rd_ready = (rstate == FULL);
        rd_busy  = (rstate == READ);
        rd_len   = MEM_SIZE'(hw_q[rptr_q]);
        rd       = rd_q;
        err      = err_q;
    end

endmodule

// File: tb/tb_fmap_buf.sv
// tb_fmap_buf: directed self-checking bench for fmap_buf.
// Read results are predicted into a queue when the address is driven and
// popped for comparison once the registered data is due.
module tb_fmap_buf;

    localparam int DATA_SIZE  = 16;
    localparam int MEM_SIZE   = 16;
    localparam int DEPTH_BITS = 12;

    logic                 clk;
    logic                 rst;
    logic                 wr_start;
    logic                 wr_ready;
    logic                 we;
    logic [MEM_SIZE-1:0]  wa;
    logic [DATA_SIZE-1:0] wd;
    logic                 wr_done;
    logic                 rd_ready;
    logic                 rd_start;
    logic                 rd_busy;
    logic [MEM_SIZE-1:0]  ra;
    logic [DATA_SIZE-1:0] rd;
    logic [MEM_SIZE-1:0]  rd_len;
    logic                 rd_release;
    logic                 err;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] exp_q [$];

    fmap_buf #(
        .DATA_SIZE (DATA_SIZE),
        .MEM_SIZE  (MEM_SIZE),
        .DEPTH_BITS(DEPTH_BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_start  (wr_start),
        .wr_ready  (wr_ready),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .wr_done   (wr_done),
        .rd_ready  (rd_ready),
        .rd_start  (rd_start),
        .rd_busy   (rd_busy),
        .ra        (ra),
        .rd        (rd),
        .rd_len    (rd_len),
        .rd_release(rd_release),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one clock; inputs and checks both sit 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_wr_start();
        wr_start = 1'b1; step(); wr_start = 1'b0;
    endtask

    task automatic pulse_wr_done();
        wr_done = 1'b1; step(); wr_done = 1'b0;
    endtask

    task automatic pulse_rd_start();
        rd_start = 1'b1; step(); rd_start = 1'b0;
    endtask

    task automatic pulse_rd_release();
        rd_release = 1'b1; step(); rd_release = 1'b0;
    endtask

    task automatic write_word(input logic [MEM_SIZE-1:0] a, input logic [DATA_SIZE-1:0] d);
        we = 1'b1; wa = a; wd = d; step(); we = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [MEM_SIZE-1:0] a, input logic [31:0] expv);
        ra = a;
        exp_q.push_back(expv);
        step();
        chk(tag, {16'd0, rd}, exp_q.pop_front());
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        rst = 1'b0; wr_start = 1'b0; we = 1'b0; wa = '0; wd = '0; wr_done = 1'b0;
        rd_start = 1'b0; ra = '0; rd_release = 1'b0;
        step(); step();
        rst = 1'b1;
        step();

        // Reset values
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("rst_rd_ready", {31'd0, rd_ready}, 32'd0);
        chk("rst_rd_busy", {31'd0, rd_busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rd", {16'd0, rd}, 32'd0);
        chk("rst_rd_len", {16'd0, rd_len}, 32'd0);

        // Asynchronous reset mid-WRITE
        pulse_wr_start();
        chk("grant0_wr_ready", {31'd0, wr_ready}, 32'd1);
        write_word(16'd0, 16'h0055);
        chk("pre_rst_rd_len", {16'd0, rd_len}, 32'd1);
        we = 1'b1; wa = 16'd1; wd = 16'h0066;
        #2 rst = 1'b0;
        #1;
        chk("async_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("async_rd_len", {16'd0, rd_len}, 32'd0);
        chk("async_err", {31'd0, err}, 32'd0);
        we = 1'b0;
        step();
        rst = 1'b1;
        step();
        pulse_wr_start();
        chk("regrant_wr_ready", {31'd0, wr_ready}, 32'd1);

        // Single pass on bank 0
        for (int i = 0; i < 8; i++) write_word(16'(i), 16'(16'h100 + i));
        pulse_wr_done();
        chk("sp_rd_ready", {31'd0, rd_ready}, 32'd1);
        chk("sp_rd_len", {16'd0, rd_len}, 32'd8);
        chk("sp_wr_ready", {31'd0, wr_ready}, 32'd0);
        pulse_rd_start();
        chk("sp_rd_busy", {31'd0, rd_busy}, 32'd1);
        read_chk("sp_rd3", 16'd3, 32'h103);
        read_chk("sp_rd7", 16'd7, 32'h107);
        pulse_rd_release();
        chk("sp_rel_rd_ready", {31'd0, rd_ready}, 32'd0);
        chk("sp_rel_rd_busy", {31'd0, rd_busy}, 32'd0);
        step();
        chk("sp_idle_rd_zero", {16'd0, rd}, 32'd0);

        // Ping-pong overlap: bank 1 filled with 0x300+wa, read while bank 0 fills
        pulse_wr_start();
        for (int i = 0; i < 8; i++) write_word(16'(i), 16'(16'h300 + i));
        pulse_wr_done();
        pulse_rd_start();
        pulse_wr_start();
        chk("pp_wr_ready", {31'd0, wr_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; wa = 16'(i); wd = 16'(16'h200 + i);
            ra = 16'(7 - i);
            exp_q.push_back(32'(16'h300 + 7 - i));
            step();
            chk("pp_concurrent_rd", {16'd0, rd}, exp_q.pop_front());
        end
        we = 1'b0;
        rd_release = 1'b1; wr_done = 1'b1;
        step();
        rd_release = 1'b0; wr_done = 1'b0;
        chk("pp_rd_ready", {31'd0, rd_ready}, 32'd1);
        chk("pp_rd_len", {16'd0, rd_len}, 32'd8);
        chk("pp_err", {31'd0, err}, 32'd0);
        pulse_rd_start();
        read_chk("pp_rd5", 16'd5, 32'h205);

        // Back-pressure: make both banks FULL
        pulse_rd_release();
        pulse_wr_start();
        write_word(16'd0, 16'h0500);
        pulse_wr_done();
        pulse_wr_start();
        for (int i = 0; i < 4; i++) write_word(16'(i), 16'(16'h400 + i));
        pulse_wr_done();
        pulse_wr_start();
        chk("bp_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("bp_err", {31'd0, err}, 32'd0);
        chk("bp_rd_ready", {31'd0, rd_ready}, 32'd1);
        pulse_rd_start();
        read_chk("bp_rd0", 16'd0, 32'h500);
        pulse_rd_release();
        pulse_wr_start();
        chk("bp_retry_wr_ready", {31'd0, wr_ready}, 32'd1);
        pulse_wr_done();
        pulse_rd_start();
        read_chk("bp_rd2", 16'd2, 32'h402);
        pulse_rd_release();

        // Rejected write (wr_ready=0) leaves bank 0 memory intact
        chk("rej_pre_err", {31'd0, err}, 32'd0);
        write_word(16'd2, 16'h0BAD);
        chk("rej_err", {31'd0, err}, 32'd1);
        pulse_wr_start();
        pulse_wr_done();
        pulse_rd_start();
        pulse_rd_release();
        chk("rej_empty_rd_len", {16'd0, rd_len}, 32'd0);
        pulse_rd_start();
        read_chk("rej_mem_kept", 16'd2, 32'h402);
        pulse_rd_release();

        // Out-of-range write address
        do_reset();
        chk("oor_rst_err", {31'd0, err}, 32'd0);
        pulse_wr_start();
        write_word(16'd3, 16'h0033);
        write_word(16'd4096, 16'h0044);
        chk("oor_err", {31'd0, err}, 32'd1);
        chk("oor_rd_len", {16'd0, rd_len}, 32'd4);

        // rd_start with no FULL bank
        do_reset();
        pulse_rd_start();
        chk("rdstart_err", {31'd0, err}, 32'd1);
        chk("rdstart_busy", {31'd0, rd_busy}, 32'd0);

        // Sparse write coincident with wr_done
        do_reset();
        pulse_wr_start();
        we = 1'b1; wa = 16'd10; wd = 16'hABCD; wr_done = 1'b1;
        step();
        we = 1'b0; wr_done = 1'b0;
        chk("sparse_rd_ready", {31'd0, rd_ready}, 32'd1);
        chk("sparse_rd_len", {16'd0, rd_len}, 32'd11);
        chk("sparse_err", {31'd0, err}, 32'd0);
        pulse_rd_start();
        read_chk("sparse_rd10", 16'd10, 32'hABCD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
